pc_gen: RTL and testbench

Program-counter and instruction-issue stage directly upstream of the fetch stage. Holds the PC, drives the instruction-memory word address, waits out the fixed memory read latency, then pulses `f_valid` so fetch latches the returned word. It advances the PC only when the previous instruction retires, through a write, a store or a jump completion. The result is one instruction in flight, in program order.

---
 rtl/pc_gen.sv | 137 +++++++++++++
 tb/tb_pc_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Program counter / issue stage: holds the PC, drives the imem word address,
// waits out the read latency and pulses f_valid, one instruction in flight.
// Latency: start or retire -> f_valid after MEM_LAT+1 cycles. stall holds ISSUE.
//
// Ports:
//   clk, rstn                   clock, async active-low reset
//   start                       begin issuing (honoured in IDLE and HALT only)
//   stall                       withhold f_valid while in ISSUE
//   write/store/jump_finish     retire pulses, honoured only in BUSY
//   jump_taken, jump_target     redirect qualifier and target, valid with jump_finish
//   halt_req                    stop after the retiring instruction
//   iaddr, pc                   current fetch address (identical values)
//   f_valid                     instruction word valid on the memory bus this cycle
//   running                     high in WAIT, ISSUE and BUSY
//   inst_count                  number of f_valid cycles since reset, wrapping
module pc_gen #(
    parameter int                 ADDR_W   = 15,
    parameter int                 MEM_LAT  = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              stall,
    input  logic              write_finish,
    input  logic              store_finish,
    input  logic              jump_finish,
    input  logic              jump_taken,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] iaddr,
    output logic [ADDR_W-1:0] pc,
    output logic              f_valid,
    output logic              running,
    output logic [31:0]       inst_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_BUSY,
        S_HALT
    } state_t;

    localparam logic [3:0]        LAT_LOAD = 4'(MEM_LAT);
    localparam logic [ADDR_W-1:0] PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [3:0]        lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       inst_cnt_q;
    logic              retire;
    logic              issue_fire;

    // Simultaneous retire pulses collapse into a single retire.
    assign retire = write_finish | store_finish | jump_finish;

    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        pc_d       = pc_q;
        issue_fire = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_WAIT;
                    lat_cnt_d = LAT_LOAD;
                end
            end
            S_WAIT: begin
                // Counter holds the remaining latency cycles including this one.
                lat_cnt_d = lat_cnt_q - 4'd1;
                if (lat_cnt_q == 4'd1) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                issue_fire = ~stall;
                if (!stall) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (retire) begin
                    // Jump redirect wins over sequential advance.
                    if (jump_finish && jump_taken) begin
                        pc_d = jump_target;
                    end else begin
                        pc_d = pc_q + PC_ONE;
                    end
                    if (halt_req) begin
                        state_d = S_HALT;
                    end else begin
                        state_d   = S_WAIT;
                        lat_cnt_d = LAT_LOAD;
                    end
                end
            end
            S_HALT: begin
                if (start) begin
                    pc_d      = RESET_PC;
                    state_d   = S_WAIT;
                    lat_cnt_d = LAT_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            lat_cnt_q  <= 4'd0;
            pc_q       <= RESET_PC;
            inst_cnt_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            pc_q      <= pc_d;
            if (issue_fire) begin
                inst_cnt_q <= inst_cnt_q + 32'd1;
            end
        end
    end

    // pc is the registered memory address, so iaddr follows it on the same edge.
    assign iaddr      = pc_q;
    assign pc         = pc_q;
    assign f_valid    = issue_fire;
    assign running    = (state_q == S_WAIT) || (state_q == S_ISSUE) || (state_q == S_BUSY);
    assign inst_count = inst_cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    localparam int AW  = 15;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic          write_finish = 1'b0;
    logic          store_finish = 1'b0;
    logic          jump_finish = 1'b0;
    logic          jump_taken = 1'b0;
    logic [AW-1:0] jump_target = '0;
    logic          halt_req = 1'b0;
    logic [AW-1:0] iaddr;
    logic [AW-1:0] pc;
    logic          f_valid;
    logic          running;
    logic [31:0]   inst_count;

    pc_gen #(
        .ADDR_W   (AW),
        .MEM_LAT  (LAT),
        .RESET_PC ('0)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .stall        (stall),
        .write_finish (write_finish),
        .store_finish (store_finish),
        .jump_finish  (jump_finish),
        .jump_taken   (jump_taken),
        .jump_target  (jump_target),
        .halt_req     (halt_req),
        .iaddr        (iaddr),
        .pc           (pc),
        .f_valid      (f_valid),
        .running      (running),
        .inst_count   (inst_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural PC and issued-instruction count.
    logic [AW-1:0] m_pc;
    logic [31:0]   m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        start        = 1'b0;
        stall        = 1'b0;
        write_finish = 1'b0;
        store_finish = 1'b0;
        jump_finish  = 1'b0;
        jump_taken   = 1'b0;
        jump_target  = '0;
        halt_req     = 1'b0;
    endtask

    // Entered just after the edge that starts WAIT. Expects exactly LAT quiet
    // cycles, nstall withheld ISSUE cycles, then one f_valid at the model PC.
    task automatic expect_fetch(input int nstall);
        for (int i = 0; i < LAT; i++) begin
            // Noise that must be ignored outside BUSY / IDLE / HALT.
            write_finish = 1'($urandom_range(0, 1));
            jump_finish  = 1'($urandom_range(0, 1));
            jump_taken   = 1'b1;
            jump_target  = AW'($urandom);
            start        = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("wait_fv", 32'(f_valid), 32'd0);
            chk("wait_iaddr", 32'(iaddr), 32'(m_pc));
            chk("wait_run", 32'(running), 32'd1);
            tick();
        end
        clr_in();
        for (int i = 0; i < nstall; i++) begin
            stall = 1'b1;
            @(negedge clk);
            chk("stall_fv", 32'(f_valid), 32'd0);
            chk("stall_iaddr", 32'(iaddr), 32'(m_pc));
            tick();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("issue_fv", 32'(f_valid), 32'd1);
        chk("issue_iaddr", 32'(iaddr), 32'(m_pc));
        chk("issue_pc", 32'(pc), 32'(m_pc));
        tick();
        m_cnt = m_cnt + 32'd1;
        chk("inst_count", inst_count, m_cnt);
    endtask

    task automatic do_start(input int nstall);
        start = 1'b1;
        tick();
        clr_in();
        expect_fetch(nstall);
    endtask

    // Called in the first BUSY cycle; idles 'idle' cycles then retires.
    task automatic retire(input logic w, input logic s, input logic j, input logic jt,
                          input logic [AW-1:0] tgt, input logic h, input int nstall,
                          input int idle);
        for (int i = 0; i < idle; i++) begin
            stall    = 1'($urandom_range(0, 1));
            start    = 1'($urandom_range(0, 1));
            halt_req = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("busy_fv", 32'(f_valid), 32'd0);
            chk("busy_iaddr", 32'(iaddr), 32'(m_pc));
            tick();
            clr_in();
        end
        write_finish = w;
        store_finish = s;
        jump_finish  = j;
        jump_taken   = jt;
        jump_target  = tgt;
        halt_req     = h;
        if (j && jt) m_pc = tgt;
        else         m_pc = m_pc + AW'(1);
        tick();
        clr_in();
        if (h) begin
            @(negedge clk);
            chk("halt_run", 32'(running), 32'd0);
            chk("halt_fv", 32'(f_valid), 32'd0);
            chk("halt_iaddr", 32'(iaddr), 32'(m_pc));
            tick();
        end else begin
            expect_fetch(nstall);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic w, s, j, jt;

        // Reset values while held in reset.
        @(negedge clk);
        chk("rst_iaddr", 32'(iaddr), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_fv", 32'(f_valid), 32'd0);
        chk("rst_run", 32'(running), 32'd0);
        chk("rst_cnt", inst_count, 32'd0);
        tick();
        rstn = 1'b1;
        tick();

        // Retire pulses and stall in IDLE are ignored.
        write_finish = 1'b1; jump_finish = 1'b1; jump_taken = 1'b1;
        jump_target = 15'h55; stall = 1'b1;
        tick();
        clr_in();
        @(negedge clk);
        chk("idle_pc", 32'(pc), 32'd0);
        chk("idle_run", 32'(running), 32'd0);
        chk("idle_fv", 32'(f_valid), 32'd0);
        tick();

        m_pc  = '0;
        m_cnt = '0;

        // Startup: f_valid exactly in cycle LAT+1 at address 0.
        do_start(0);

        // Three back-to-back write retires at minimum period.
        repeat (3) retire(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 0, 0);

        // Taken and not-taken jumps.
        retire(1'b0, 1'b0, 1'b1, 1'b1, 15'h100, 1'b0, 0, 0);
        retire(1'b0, 1'b0, 1'b1, 1'b0, 15'h200, 1'b0, 0, 0);

        // PC wrap at the top of the address space.
        retire(1'b0, 1'b0, 1'b1, 1'b1, 15'h7FFF, 1'b0, 0, 0);
        retire(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 0, 0);

        // Simultaneous write + taken jump counts as one retire.
        retire(1'b1, 1'b0, 1'b1, 1'b1, 15'h20, 1'b0, 0, 0);

        // Five stalled cycles in ISSUE.
        retire(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 5, 0);

        // Randomized retire mix.
        for (int n = 0; n < 40; n++) begin
            w  = 1'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 1));
            j  = 1'($urandom_range(0, 1));
            jt = 1'($urandom_range(0, 1));
            if (!(w || s || j)) w = 1'b1;
            retire(w, s, j, jt, AW'($urandom), 1'b0,
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Halt, ignore everything but start, then resume at RESET_PC.
        retire(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 0, 1);
        for (int i = 0; i < 6; i++) begin
            write_finish = 1'b1; jump_finish = 1'b1; jump_taken = 1'b1;
            jump_target = AW'($urandom); stall = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("halted_fv", 32'(f_valid), 32'd0);
            chk("halted_run", 32'(running), 32'd0);
            chk("halted_pc", 32'(pc), 32'(m_pc));
            tick();
            clr_in();
        end
        m_pc = '0;
        do_start(1);

        // Reset asserted mid-WAIT aborts the pending issue.
        write_finish = 1'b1;
        tick();
        clr_in();
        rstn = 1'b0;
        #1;
        chk("arst_iaddr", 32'(iaddr), 32'd0);
        chk("arst_pc", 32'(pc), 32'd0);
        chk("arst_fv", 32'(f_valid), 32'd0);
        chk("arst_run", 32'(running), 32'd0);
        chk("arst_cnt", inst_count, 32'd0);
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_fv", 32'(f_valid), 32'd0);
            chk("post_rst_run", 32'(running), 32'd0);
            tick();
        end
        m_pc  = '0;
        m_cnt = '0;
        do_start(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
